// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD busy-flag reader: state encoding and
// default bus timing at a 50 MHz clock.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HI_U,
        ST_GAP_U,
        ST_E_HI_L,
        ST_GAP_L,
        ST_DONE
    } lcd_state_t;

    localparam int          DEF_T_SETUP   = 2;
    localparam int          DEF_T_EHIGH   = 12;
    localparam int          DEF_T_GAP     = 50;
    localparam logic [15:0] DEF_MAX_POLLS = 16'd1000;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable 8-bit down-counter that times every bus phase; tc is high
// while the count is zero, so a load of N-1 yields an N-cycle phase.
module lcd_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tc
);

    logic [7:0] cnt;

    // NOTE: registered state always uses non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tc = (cnt == 8'd0);

endmodule

// File: rtl/lcd_busy_reader.sv
// Polls the LCD busy flag and address counter through two 4-bit read
// cycles, repeating while the flag is set, up to MAX_POLLS reads.
module lcd_busy_reader
    import lcd_pkg::*;
#(
    parameter int          T_SETUP   = lcd_pkg::DEF_T_SETUP,
    parameter int          T_EHIGH   = lcd_pkg::DEF_T_EHIGH,
    parameter int          T_GAP     = lcd_pkg::DEF_T_GAP,
    parameter logic [15:0] MAX_POLLS = lcd_pkg::DEF_MAX_POLLS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] lcd_data_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_drive_en,
    output logic       busy,
    output logic       done,
    output logic       bf,
    output logic [6:0] addr,
    output logic       timeout
);

    lcd_state_t  state;
    lcd_state_t  state_next;
    logic        tc;
    logic        load;
    logic [7:0]  load_val;
    logic [15:0] poll_cnt;
    logic [15:0] poll_cnt_inc;

    function automatic logic [7:0] phase_len(input lcd_state_t s);
        case (s)
            ST_SETUP:             return 8'(T_SETUP - 1);
            ST_E_HI_U, ST_E_HI_L: return 8'(T_EHIGH - 1);
            ST_GAP_U, ST_GAP_L:   return 8'(T_GAP - 1);
            default:              return 8'd0;
        endcase
    endfunction

    // Every state change reloads the timer with the new phase length.
    assign load     = (state_next != state);
    assign load_val = phase_len(state_next);

    lcd_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    assign poll_cnt_inc = (poll_cnt >= MAX_POLLS) ? poll_cnt : poll_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves
    // an output unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETUP;
            ST_SETUP:  if (tc) state_next = ST_E_HI_U;
            ST_E_HI_U: if (tc) state_next = ST_GAP_U;
            ST_GAP_U:  if (tc) state_next = ST_E_HI_L;
            ST_E_HI_L: if (tc) state_next = ST_GAP_L;
            ST_GAP_L: begin
                if (tc) begin
                    if (bf && (poll_cnt_inc < MAX_POLLS)) state_next = ST_SETUP;
                    else                                  state_next = ST_DONE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        lcd_e = 1'b0;
        lcd_rw = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_SETUP, ST_GAP_U, ST_GAP_L: begin
                lcd_rw = 1'b1;
                busy = 1'b1;
            end
            ST_E_HI_U, ST_E_HI_L: begin
                lcd_e = 1'b1;
                lcd_rw = 1'b1;
                busy = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign lcd_rs       = 1'b0;
    assign lcd_drive_en = ~lcd_rw;

    // Results are captured on the last E-high cycle of each nibble and
    // held until the next request overwrites them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bf <= 1'b0;
            addr <= 7'd0;
            timeout <= 1'b0;
            poll_cnt <= 16'd0;
        end else begin
            if (state == ST_IDLE && start) poll_cnt <= 16'd0;
            if (state == ST_E_HI_U && tc) begin
                bf <= lcd_data_in[3];
                addr[6:4] <= lcd_data_in[2:0];
            end
            if (state == ST_E_HI_L && tc) addr[3:0] <= lcd_data_in;
            if (state == ST_GAP_L && tc) poll_cnt <= poll_cnt_inc;
            if (state_next == ST_DONE && state != ST_DONE) timeout <= bf;
        end
    end

endmodule

// File: doc/lcd_busy_reader.md
LCD_BUSY_READER -- requirements
Module: lcd_busy_reader

Interface
- REQ-001: Parameter T_SETUP, default 2; cycles RS/RW are stable before E rises (40 ns at 50 MHz).
- REQ-002: Parameter T_EHIGH, default 12; cycles E is held high per nibble read (240 ns).
- REQ-003: Parameter T_GAP, default 50; cycles E is held low after each nibble (1 us).
- REQ-004: Parameter MAX_POLLS, default 16'd1000; maximum busy-flag reads per request before timeout.
- REQ-005: clk  input  1  system clock, 50 MHz.
- REQ-006: reset  input  1  synchronous, active-low reset; sampled on posedge clk only.
- REQ-007: start  input  1  single-cycle request to poll the LCD busy flag.
- REQ-008: lcd_data_in  input  4  LCD data nibble (SF_D[11:8]) as read from the pad.
- REQ-009: lcd_e  output  1  LCD enable strobe.
- REQ-010: lcd_rs  output  1  register select; 0 throughout (instruction/status register).
- REQ-011: lcd_rw  output  1  1 = read cycle.
- REQ-012: lcd_drive_en  output  1  1 = FPGA may drive the data pads; 0 = pads tristated.
- REQ-013: busy  output  1  block is executing a request.
- REQ-014: done  output  1  one-cycle pulse at request completion.
- REQ-015: bf  output  1  last busy flag read.
- REQ-016: addr  output  7  last address counter read.
- REQ-017: timeout  output  1  request ended with the busy flag still set; valid with done.

Function
- REQ-018: States: IDLE, SETUP, E_HI_U, GAP_U, E_HI_L, GAP_L, DONE.
- REQ-019: In IDLE, when start=1 the block SHALL move to SETUP, clear the poll count, set busy=1, lcd_rw=1 and lcd_drive_en=0.
- REQ-020: start SHALL be ignored while busy=1.
- REQ-021: SETUP lasts T_SETUP cycles, then E_HI_U; E_HI_U lasts T_EHIGH cycles with lcd_e=1, then GAP_U.
- REQ-022: On the last E_HI_U cycle the block SHALL latch lcd_data_in[3] into bf and lcd_data_in[2:0] into addr[6:4].
- REQ-023: GAP_U lasts T_GAP cycles with lcd_e=0, then E_HI_L (T_EHIGH cycles, lcd_e=1).
- REQ-024: On the last E_HI_L cycle the block SHALL latch lcd_data_in[3:0] into addr[3:0].
- REQ-025: GAP_L lasts T_GAP cycles and increments the poll count on its last cycle.
- REQ-026: At the end of GAP_L: if bf=1 and poll count < MAX_POLLS, go to SETUP; otherwise go to DONE.
- REQ-027: DONE lasts 1 cycle with done=1, timeout=bf, lcd_rw=0, lcd_drive_en=1, busy=0; next state IDLE.
- REQ-028: Latency: start sampled on edge k with BF=0 gives done=1 in cycle k+127 (2+12+50+12+50+1); each extra poll adds 126 cycles.
- REQ-029: lcd_rw SHALL never change while lcd_e=1; lcd_drive_en SHALL be 0 whenever lcd_rw=1.
- REQ-030: bf, addr and timeout SHALL hold their values from done until the next request reaches its latch points.
- REQ-031: The phase timer SHALL be 8 bits and the poll counter 16 bits; reaching MAX_POLLS SHALL saturate the counter, never wrap it.

Reset
- REQ-032: When reset=0 on a clock edge: state=IDLE, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_drive_en=1, busy=0, done=0, bf=0, addr=0, timeout=0, all counters 0.
- REQ-033: Reset mid-request SHALL abort it on that edge, with no done pulse; lcd_e SHALL fall in the same cycle.

Structure
- REQ-034: A shared package lcd_pkg SHALL hold the state encoding and the default timing constants (T_SETUP, T_EHIGH, T_GAP, MAX_POLLS).
- REQ-035: A sub-module lcd_phase_timer SHALL provide the 8-bit loadable down-counter with a terminal-count flag, used for all phase durations.

Verification
- REQ-036: Test 1: start with lcd_data_in=4'h0 -> done at k+127, bf=0, addr=0, timeout=0, lcd_e high exactly 24 cycles in total.
- REQ-037: Test 2: upper nibble 4'h5, lower nibble 4'hA (BF=0) -> addr=7'h5A, bf=0.
- REQ-038: Test 3: BF=1 for 3 polls, then 0 -> done at k+1+4*126, timeout=0, 4 E-pulse pairs.
- REQ-039: Test 4: BF stuck at 1 with MAX_POLLS=4 -> done after 4 polls, bf=1, timeout=1.
- REQ-040: Test 5: reset=0 asserted during E_HI_L -> next cycle lcd_e=0, busy=0, no done; start 3 cycles later completes normally.
- REQ-041: Test 6: second start pulse during busy -> ignored; exactly one done pulse; protocol checker for REQ-029 runs throughout.
